// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the multi-cycle accumulator controller: opcodes,
// FSM states, ALU operation codes and ALU B-source selects.
package cpu_ctrl_pkg;

  localparam logic [3:0] OP_LOAD     = 4'h0;
  localparam logic [3:0] OP_STORE    = 4'h1;
  localparam logic [3:0] OP_JMP      = 4'h2;
  localparam logic [3:0] OP_BRZ      = 4'h3;
  localparam logic [3:0] OP_ADD      = 4'h4;
  localparam logic [3:0] OP_SUB      = 4'h5;
  localparam logic [3:0] OP_AND      = 4'h6;
  localparam logic [3:0] OP_OR       = 4'h7;
  localparam logic [3:0] OP_NOT      = 4'h8;
  localparam logic [3:0] OP_MOVETO   = 4'h9;
  localparam logic [3:0] OP_MOVEFROM = 4'hA;
  localparam logic [3:0] OP_ADDI     = 4'hB;
  localparam logic [3:0] OP_SUBI     = 4'hC;
  localparam logic [3:0] OP_ANDI     = 4'hD;
  localparam logic [3:0] OP_ORI      = 4'hE;
  localparam logic [3:0] OP_SYS      = 4'hF;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADR, MEM_RD, LOAD_WB, MEM_WR,
    JUMP, EXEC_R, EXEC_I, ALU_WB, HALT
  } state_t;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_NOTA  = 3'b100;
  localparam logic [2:0] ALU_PASSB = 3'b101;
  localparam logic [2:0] ALU_PASSA = 3'b110;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational ALU operation select from the current controller state and
// the latched opcode.
module alu_op_decoder
  import cpu_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] opcode,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (state)
      FETCH:           alucontrol = ALU_ADD;
      DECODE:          alucontrol = ALU_PASSA;
      MEM_ADR, JUMP:   alucontrol = ALU_PASSB;
      EXEC_R: begin
        case (opcode)
          OP_ADD:      alucontrol = ALU_ADD;
          OP_SUB:      alucontrol = ALU_SUB;
          OP_AND:      alucontrol = ALU_AND;
          OP_OR:       alucontrol = ALU_OR;
          OP_NOT:      alucontrol = ALU_NOTA;
          OP_MOVETO:   alucontrol = ALU_PASSA;
          OP_MOVEFROM: alucontrol = ALU_PASSB;
          default:     alucontrol = ALU_ADD;
        endcase
      end
      EXEC_I: begin
        case (opcode)
          OP_SUBI:     alucontrol = ALU_SUB;
          OP_ANDI:     alucontrol = ALU_AND;
          OP_ORI:      alucontrol = ALU_OR;
          default:     alucontrol = ALU_ADD;
        endcase
      end
      default:         alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the 16-bit multi-cycle accumulator datapath; drives
// every datapath enable/select per cycle and tracks the branch zero flag.
module multicycle_controller
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        zero,
  output logic        pwrite,
  output logic        iwrite,
  output logic        regwrite,
  output logic        memwrite,
  output logic        adrsrc,
  output logic        memtoreg,
  output logic        alusrca,
  output logic        regdest,
  output logic [1:0]  alusrcb,
  output logic [2:0]  alucontrol,
  output logic        halted,
  output logic        retire
);

  state_t     state_q, state_d;
  logic       zflag_q;
  logic [3:0] opcode;
  logic [2:0] alu_op;
  logic       is_halt;
  logic       unused_instr_bits;

  assign opcode            = instr[15:12];
  assign is_halt           = instr[0];
  assign unused_instr_bits = ^instr[11:1];

  alu_op_decoder u_alu_op_decoder (
    .state      (state_q),
    .opcode     (opcode),
    .alucontrol (alu_op)
  );

  // zflag_q snapshots R0's zero flag in DECODE for a later BRZ
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      zflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE)
        zflag_q <= zero;
    end
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE:                  state_d = MEM_ADR;
          OP_JMP, OP_BRZ:                     state_d = JUMP;
          OP_ADD, OP_SUB, OP_AND, OP_OR,
          OP_NOT, OP_MOVETO, OP_MOVEFROM:     state_d = EXEC_R;
          OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI:  state_d = EXEC_I;
          default:                            state_d = is_halt ? HALT : FETCH;
        endcase
      end
      MEM_ADR: state_d = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
      MEM_RD:  state_d = LOAD_WB;
      EXEC_R,
      EXEC_I:  state_d = ALU_WB;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Outputs follow state only; reset blanks them so an aborted strobe never escapes
  always_comb begin
    pwrite     = 1'b0;
    iwrite     = 1'b0;
    regwrite   = 1'b0;
    memwrite   = 1'b0;
    adrsrc     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    regdest    = 1'b0;
    alusrcb    = SRCB_REG;
    alucontrol = alu_op;
    halted     = 1'b0;
    retire     = 1'b0;
    case (state_q)
      FETCH: begin
        iwrite  = 1'b1;
        pwrite  = 1'b1;
        alusrcb = SRCB_ONE;
      end
      DECODE: begin
        alusrca = 1'b1;
        retire  = (opcode == OP_SYS) && !is_halt;
      end
      MEM_ADR: alusrcb = SRCB_IMM;
      MEM_RD:  adrsrc  = 1'b1;
      LOAD_WB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      MEM_WR: begin
        adrsrc   = 1'b1;
        memwrite = 1'b1;
        retire   = 1'b1;
      end
      JUMP: begin
        alusrcb = SRCB_IMM;
        pwrite  = (opcode == OP_JMP) || ((opcode == OP_BRZ) && zflag_q);
        retire  = 1'b1;
      end
      EXEC_R: alusrca = 1'b1;
      EXEC_I: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      ALU_WB: begin
        regwrite = 1'b1;
        regdest  = (opcode == OP_MOVETO);
        retire   = 1'b1;
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
    if (rst) begin
      pwrite     = 1'b0;
      iwrite     = 1'b0;
      regwrite   = 1'b0;
      memwrite   = 1'b0;
      adrsrc     = 1'b0;
      memtoreg   = 1'b0;
      alusrca    = 1'b0;
      regdest    = 1'b0;
      alusrcb    = SRCB_REG;
      alucontrol = ALU_ADD;
      halted     = 1'b0;
      retire     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench for multicycle_controller: an instruction-level
// model expands each instruction into its per-cycle control words.
module tb_multicycle_controller;

  typedef struct packed {
    logic       pwrite;
    logic       iwrite;
    logic       regwrite;
    logic       memwrite;
    logic       adrsrc;
    logic       memtoreg;
    logic       alusrca;
    logic       regdest;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic       halted;
    logic       retire;
  } ctl_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instr = 16'hF000;
  logic        zero = 1'b0;
  logic        pwrite, iwrite, regwrite, memwrite, adrsrc, memtoreg;
  logic        alusrca, regdest, halted, retire;
  logic [1:0]  alusrcb;
  logic [2:0]  alucontrol;

  ctl_t exp_q[$];
  ctl_t model_seq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .zero       (zero),
    .pwrite     (pwrite),
    .iwrite     (iwrite),
    .regwrite   (regwrite),
    .memwrite   (memwrite),
    .adrsrc     (adrsrc),
    .memtoreg   (memtoreg),
    .alusrca    (alusrca),
    .regdest    (regdest),
    .alusrcb    (alusrcb),
    .alucontrol (alucontrol),
    .halted     (halted),
    .retire     (retire)
  );

  // Cycle-by-cycle control words an instruction should produce, built from
  // the instruction's class; a HALT gets a few cycles of parked status.
  function automatic void buildSeq(input logic [15:0] ins, input bit zd);
    ctl_t c;
    logic [3:0] op;
    op = ins[15:12];
    model_seq.delete();
    c = '0; c.pwrite = 1; c.iwrite = 1; c.alusrcb = 2'b01; c.alucontrol = 3'b000;
    model_seq.push_back(c);
    c = '0; c.alusrca = 1; c.alucontrol = 3'b110; c.retire = (op == 4'hF) && !ins[0];
    model_seq.push_back(c);
    if (op <= 4'h1) begin
      c = '0; c.alusrcb = 2'b10; c.alucontrol = 3'b101;
      model_seq.push_back(c);
      if (op == 4'h0) begin
        c = '0; c.adrsrc = 1;
        model_seq.push_back(c);
        c = '0; c.memtoreg = 1; c.regwrite = 1; c.retire = 1;
        model_seq.push_back(c);
      end else begin
        c = '0; c.adrsrc = 1; c.memwrite = 1; c.retire = 1;
        model_seq.push_back(c);
      end
    end else if (op <= 4'h3) begin
      c = '0; c.alusrcb = 2'b10; c.alucontrol = 3'b101; c.retire = 1;
      c.pwrite = (op == 4'h2) || zd;
      model_seq.push_back(c);
    end else if (op <= 4'hE) begin
      c = '0; c.alusrca = 1;
      case (op)
        4'h4, 4'hB: c.alucontrol = 3'b000;
        4'h5, 4'hC: c.alucontrol = 3'b001;
        4'h6, 4'hD: c.alucontrol = 3'b010;
        4'h7, 4'hE: c.alucontrol = 3'b011;
        4'h8:       c.alucontrol = 3'b100;
        4'h9:       c.alucontrol = 3'b110;
        default:    c.alucontrol = 3'b101;
      endcase
      c.alusrcb = (op >= 4'hB) ? 2'b10 : 2'b00;
      model_seq.push_back(c);
      c = '0; c.regwrite = 1; c.retire = 1; c.regdest = (op == 4'h9);
      model_seq.push_back(c);
    end else if (ins[0]) begin
      c = '0; c.halted = 1;
      repeat (4) model_seq.push_back(c);
    end
  endfunction

  // Issue one instruction; abortAt >= 0 asserts rst in that cycle instead.
  task automatic applyStimulus(input logic [15:0] ins, input bit zd, input int abortAt);
    buildSeq(ins, zd);
    for (int i = 0; i < model_seq.size(); i++) begin
      @(posedge clk); #1;
      rst = 1'b0;
      if (i == 0) instr = ins;
      zero = (i == 1) ? zd : 1'($urandom_range(0, 1));
      if (i == abortAt) begin
        rst = 1'b1;
        exp_q.push_back('0);
        return;
      end
      exp_q.push_back(model_seq[i]);
    end
    if (ins[15:12] == 4'hF && ins[0]) begin
      @(posedge clk); #1;
      rst = 1'b1;
      zero = 1'($urandom_range(0, 1));
      exp_q.push_back('0);
    end
  endtask

  task automatic checkOutput(input ctl_t got, input ctl_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL ctl cyc=%0d instr=%h got=%b expected=%b", cyc, instr, got, exp);
    end
  endtask

  initial begin : monitor
    ctl_t got;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() > 0) begin
        got = '{pwrite, iwrite, regwrite, memwrite, adrsrc, memtoreg, alusrca,
                regdest, alusrcb, alucontrol, halted, retire};
        checkOutput(got, exp_q.pop_front());
      end
    end
  end

  initial begin : stimulus
    logic [15:0] ins;
    logic [15:0] directed[$] = '{16'hF000, 16'hF000, 16'h0005, 16'h1007,
                                 16'h3010, 16'h3010, 16'h2000, 16'h9600,
                                 16'hA600, 16'h4200, 16'h8000, 16'hB0FF,
                                 16'hE0F0};
    bit dzero[$] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0};
    int abortAt;

    repeat (2) begin
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.push_back('0);
    end
    foreach (directed[k]) applyStimulus(directed[k], dzero[k], -1);

    for (int n = 0; n < 60; n++) begin
      ins = 16'($urandom());
      if (ins[15:12] == 4'hF) ins[0] = 1'b0;
      abortAt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
      applyStimulus(ins, 1'($urandom_range(0, 1)), abortAt);
    end

    applyStimulus(16'hF001, 1'b0, -1);
    applyStimulus(16'hF000, 1'b0, -1);
    applyStimulus(16'h3000, 1'b1, -1);

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain left=%0d required=0", exp_q.size());
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore-style control FSM for the 16-bit multi-cycle accumulator datapath. It decodes `instr[15:12]` and sequences fetch, decode, address, memory, execute and write-back cycles. Each cycle it drives every datapath enable and mux select. It keeps one internal zero flag for conditional branches, and exposes `halted` and `retire` status for the bench and top level.

## Interface
Parameters:
- none. Widths are fixed by the datapath: 16-bit instruction, 3-bit ALU control.

Ports:
- `clk` in 1: single system clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `instr` in 16: IR contents from the datapath; opcode is `[15:12]`.
- `zero` in 1: ALU zero flag (combinational, current ALU result).
- `pwrite` out 1: PC load enable (PC loads `alu_result`).
- `iwrite` out 1: IR load enable.
- `regwrite` out 1: register file write enable.
- `memwrite` out 1: memory write strobe.
- `adrsrc` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `memtoreg` out 1: write-back select; 0 = ALUOut, 1 = MDR.
- `alusrca` out 1: ALU A select; 0 = PC, 1 = A (R0).
- `regdest` out 1: write address select; 0 = R0, 1 = `instr[11:9]`.
- `alusrcb` out 2: ALU B select; 00 = B (Ri), 01 = constant 1, 10 = imm_ext.
- `alucontrol` out 3: ALU op code (see package).
- `halted` out 1: high while in HALT.
- `retire` out 1: one-cycle pulse in the final state of each instruction.

## Operation
- Opcodes:
  - LOAD 0x0, STORE 0x1, JMP 0x2, BRZ 0x3.
  - ADD 0x4, SUB 0x5, AND 0x6, OR 0x7 (R0 ← R0 op Ri).
  - NOT 0x8 (R0 ← ~R0).
  - MOVETO 0x9 (Ri ← R0), MOVEFROM 0xA (R0 ← Ri).
  - ADDI 0xB, SUBI 0xC, ANDI 0xD, ORI 0xE (R0 ← R0 op imm).
  - 0xF: `instr[0]`=0 is NOP, `instr[0]`=1 is HALT.
- Any output not listed for a state is 0.
- States and outputs:
  - FETCH: adrsrc=0, iwrite=1, alusrca=0, alusrcb=01, ADD, pwrite=1. → DECODE.
  - DECODE: alusrca=1, PASSA. Register `zflag_q ← zero` (zero flag of R0). Branch by opcode:
    - LOAD/STORE → MEM_ADR.
    - JMP/BRZ → JUMP.
    - register ops, NOT, MOVETO, MOVEFROM → EXEC_R.
    - immediate ops → EXEC_I.
    - NOP → FETCH.
    - HALT → HALT.
  - MEM_ADR: alusrcb=10, PASSB (ALUOut ← imm). → MEM_RD for LOAD, MEM_WR for STORE.
  - MEM_RD: adrsrc=1 (MDR captures). → LOAD_WB.
  - LOAD_WB: memtoreg=1, regwrite=1, regdest=0. retire=1. → FETCH.
  - MEM_WR: adrsrc=1, memwrite=1. retire=1. → FETCH.
  - JUMP: alusrcb=10, PASSB, pwrite = JMP | (BRZ & `zflag_q`). retire=1. → FETCH.
  - EXEC_R: alusrca=1, alusrcb=00. ALU op per instruction:
    - ADD/SUB/AND/OR: matching op.
    - NOT: NOTA.
    - MOVETO: PASSA.
    - MOVEFROM: PASSB.
    - → ALU_WB.
  - EXEC_I: alusrca=1, alusrcb=10, op ADD/SUB/AND/OR. → ALU_WB.
  - ALU_WB: memtoreg=0, regwrite=1, regdest = (MOVETO). retire=1. → FETCH.
  - HALT: all strobes 0, halted=1. Stays in HALT until `rst`.
- NOP is retired in DECODE (retire=1 there).
- `zflag_q` is written only in DECODE; it holds its value in every other state.

## Timing
- Reset: while `rst`=1, state ← FETCH, `zflag_q` ← 0, and all outputs are forced to 0 (including pwrite and iwrite).
- The first FETCH cycle is the first cycle with `rst`=0.
- Reset mid-instruction aborts the instruction. Any strobe asserted in that cycle is suppressed.
- Cycles per instruction:
  - LOAD 5; STORE 4; ALU/MOVE/immediate 4; JMP/BRZ 3; NOP 2.
  - HALT: 2 cycles to enter, then holds.
- Outputs are a pure function of state, registered `zflag_q`, and the latched `instr`. They never depend on `zero` combinationally.
- `instr` is stable from DECODE through the instruction's final state, because IR loads only in FETCH.
- Memory read is combinational: MDR and IR capture `mem_rd` at the end of MEM_RD and FETCH respectively.
- `retire` is high for exactly one cycle per instruction.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - the opcode constants;
  - the state enum (FETCH, DECODE, MEM_ADR, MEM_RD, LOAD_WB, MEM_WR, JUMP, EXEC_R, EXEC_I, ALU_WB, HALT);
  - ALU codes: ADD 000, SUB 001, AND 010, OR 011, NOTA 100, PASSB 101, PASSA 110;
  - `alusrcb` codes: SRCB_REG 00, SRCB_ONE 01, SRCB_IMM 10.
- One sub-module, `alu_op_decoder`: combinational map from opcode + state to `alucontrol`.
- The FSM, `zflag_q`, and the output decode stay in `multicycle_controller`.

## Test plan
- Reset then release, `instr`=0xF000 (NOP) → FETCH has pwrite=iwrite=1, alusrcb=01, ADD; DECODE has retire=1. PC advances once every 2 cycles.
- LOAD 0x0005 → 5-cycle sequence with correct selects. MEM_RD has adrsrc=1; LOAD_WB has memtoreg=1 and regwrite=1 with regdest=0.
- STORE 0x1007 → MEM_WR is the only cycle with memwrite=1, and adrsrc=1 there. Total 4 cycles.
- BRZ 0x3010 with `zero`=1 in DECODE → JUMP has pwrite=1 and PASSB. Repeat with `zero`=0 → pwrite=0 in JUMP.
- MOVETO 0x9600 → EXEC_R uses PASSA; ALU_WB has regdest=1. MOVEFROM 0xA600 → PASSB with regdest=0.
- HALT 0xF001, then assert `rst` in a later cycle → halted=1 and no strobes until reset. After reset: halted=0, and the first post-reset cycle is FETCH.
